// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - instruction fetch stage with PC-tagged return queue
// Optional feature: define IFQ_BYPASS_EN to forward a returning word straight to the outputs when the queue is empty.
module ifetch_queue #(
  parameter int          DEPTH       = 4,
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [15:0]              im_addr,
  output logic                     im_rd_en,
  input  logic [15:0]              im_rdata,
  input  logic                     redirect,
  input  logic [15:0]              redirect_pc,
  input  logic                     deq,
  output logic                     instr_valid,
  output logic [15:0]              instr,
  output logic [15:0]              instr_pc,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     halted
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_V = (CW+1)'(DEPTH);

  logic [15:0]   fetch_pc;
  logic          inflight;
  logic [15:0]   inflight_pc;
  logic [15:0]   buf_instr [DEPTH];
  logic [15:0]   buf_pc    [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic [CW:0]   credits_used;
  logic          buf_empty;
  logic          ret_live;
  logic          ret_halt;
  logic          byp;
  logic          issue;
  logic          deq_fire;
  logic          push;
  logic          pop;

  assign credits_used = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign buf_empty    = (count == '0);
  assign ret_live     = inflight && !redirect;
  // A returning halt word blocks the issue in its own cycle, so nothing past it is fetched.
  assign ret_halt     = ret_live && (im_rdata[15:12] == HALT_OPCODE);

`ifdef IFQ_BYPASS_EN
  assign byp = ret_live && buf_empty;
`else
  assign byp = 1'b0;
`endif

  assign issue    = !rst && !redirect && !halted && !ret_halt && (credits_used < DEPTH_V);
  assign im_rd_en = issue;
  assign im_addr  = fetch_pc;

  assign instr_valid = !buf_empty || byp;
  assign deq_fire    = deq && instr_valid && !redirect;
  assign pop         = deq_fire && !buf_empty;
  assign push        = ret_live && !(byp && deq_fire);

  always_comb begin
    instr    = 16'h0000;
    instr_pc = 16'h0000;
    if (!buf_empty) begin
      instr    = buf_instr[rd_ptr];
      instr_pc = buf_pc[rd_ptr];
    end else if (byp) begin
      instr    = im_rdata;
      instr_pc = inflight_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr[wr_ptr] <= im_rdata;
      buf_pc[wr_ptr]    <= inflight_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= 16'h0000;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      halted      <= 1'b0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      halted   <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + 16'd1;
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (ret_halt) halted <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - randomized self-checking bench for ifetch_queue
module tb_ifetch_queue;

  localparam int          DEPTH       = 4;
  localparam int          CW          = $clog2(DEPTH) + 1;
  localparam logic [15:0] RESET_PC    = 16'h0000;
  localparam logic [3:0]  HALT_OPCODE = 4'hF;
`ifdef IFQ_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic          clk;
  logic          rst;
  logic [15:0]   im_addr;
  logic          im_rd_en;
  logic [15:0]   im_rdata;
  logic          redirect;
  logic [15:0]   redirect_pc;
  logic          deq;
  logic          instr_valid;
  logic [15:0]   instr;
  logic [15:0]   instr_pc;
  logic [CW-1:0] count;
  logic          halted;

  int checks   = 0;
  int failures = 0;

  logic [15:0] halt_addr = 16'hBEEF;

  // reference model state: fetch pointer, outstanding read, FIFO contents
  logic [15:0] m_pc;
  logic [15:0] m_infl_pc;
  bit          m_infl;
  bit          m_halt;
  logic [31:0] mq[$];

  logic          exp_valid;
  logic [15:0]   exp_instr;
  logic [15:0]   exp_pc;
  logic          exp_rd_en;
  logic [15:0]   exp_addr;
  logic [CW-1:0] exp_count;
  logic          exp_halted;

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .HALT_OPCODE(HALT_OPCODE)) dut (
    .clk(clk), .rst(rst), .im_addr(im_addr), .im_rd_en(im_rd_en), .im_rdata(im_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .deq(deq), .instr_valid(instr_valid),
    .instr(instr), .instr_pc(instr_pc), .count(count), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == halt_addr) return 16'hF000;
    return 16'h1000 + a;
  endfunction

  always @(posedge clk) begin
    if (im_rd_en) im_rdata <= mem_word(im_addr);
  end

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (int'(dut.count) + int'(dut.inflight) > DEPTH) begin
        failures++;
        $display("FAIL credit_invariant: count=%0d inflight=%0d limit=%0d", dut.count, dut.inflight, DEPTH);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    mq.delete();
    m_pc      = RESET_PC;
    m_infl    = 1'b0;
    m_infl_pc = 16'h0000;
    m_halt    = 1'b0;
  endtask

  // Drive one cycle of inputs, publish the model's expected outputs, advance the model.
  task automatic step(input bit r, input logic [15:0] rpc, input bit d);
    logic [15:0] rw;
    logic [31:0] head;
    bit ret, rh, byp, fire, consumed;
    @(negedge clk);
    redirect    = r;
    redirect_pc = rpc;
    deq         = d;
    #1;
    ret = m_infl && !r;
    rw  = mem_word(m_infl_pc);
    rh  = ret && (rw[15:12] == HALT_OPCODE);
    byp = 1'b0;
`ifdef IFQ_BYPASS_EN
    byp = ret && (mq.size() == 0);
`endif
    exp_count  = CW'(mq.size());
    exp_addr   = m_pc;
    exp_halted = m_halt;
    exp_valid  = (mq.size() > 0) || byp;
    exp_instr  = 16'h0000;
    exp_pc     = 16'h0000;
    if (mq.size() > 0) begin
      head      = mq[0];
      exp_instr = head[31:16];
      exp_pc    = head[15:0];
    end else if (byp) begin
      exp_instr = rw;
      exp_pc    = m_infl_pc;
    end
    exp_rd_en = !r && !m_halt && !rh && ((mq.size() + int'(m_infl)) < DEPTH);
    if (r) begin
      mq.delete();
      m_infl = 1'b0;
      m_halt = 1'b0;
      m_pc   = rpc;
    end else begin
      fire     = d && exp_valid;
      consumed = 1'b0;
      if (fire) begin
        if (mq.size() > 0) void'(mq.pop_front());
        else consumed = 1'b1;
      end
      if (ret && !consumed) mq.push_back({rw, m_infl_pc});
      if (rh) m_halt = 1'b1;
      m_infl = exp_rd_en;
      if (exp_rd_en) begin
        m_infl_pc = m_pc;
        m_pc      = m_pc + 16'd1;
      end
    end
  endtask

  task automatic test_reset();
    #12;
    checks += 7;
    if (im_rd_en !== 1'b0)      begin failures++; $display("FAIL reset_rd_en: got %b want 0", im_rd_en); end
    if (im_addr !== RESET_PC)   begin failures++; $display("FAIL reset_addr: got %h want %h", im_addr, RESET_PC); end
    if (instr_valid !== 1'b0)   begin failures++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    if (instr !== 16'h0000)     begin failures++; $display("FAIL reset_instr: got %h want 0000", instr); end
    if (instr_pc !== 16'h0000)  begin failures++; $display("FAIL reset_pc: got %h want 0000", instr_pc); end
    if (count !== '0)           begin failures++; $display("FAIL reset_count: got %0d want 0", count); end
    if (halted !== 1'b0)        begin failures++; $display("FAIL reset_halted: got %b want 0", halted); end
    @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
  endtask

  task automatic test_stream();
    int first_valid = -1;
    int nvalid = 0;
    for (int i = 0; i < 24; i++) begin
      step(1'b0, 16'h0000, 1'b1);
      checks += 3;
      if (instr_valid !== exp_valid) begin failures++; $display("FAIL stream_valid[%0d]: got %b want %b", i, instr_valid, exp_valid); end
      if (instr !== exp_instr)       begin failures++; $display("FAIL stream_instr[%0d]: got %h want %h", i, instr, exp_instr); end
      if (instr_pc !== exp_pc)       begin failures++; $display("FAIL stream_pc[%0d]: got %h want %h", i, instr_pc, exp_pc); end
      if (instr_valid === 1'b1) begin
        nvalid++;
        if (first_valid < 0) first_valid = i;
      end
    end
    checks += 2;
    if (first_valid != LAT) begin failures++; $display("FAIL stream_first_valid: got cycle %0d want %0d", first_valid, LAT); end
    if (nvalid != 24 - LAT) begin failures++; $display("FAIL stream_throughput: got %0d valid cycles want %0d", nvalid, 24 - LAT); end
  endtask

  task automatic test_backpressure();
    step(1'b1, 16'h0000, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 16'h0000, 1'b0);
      checks += 3;
      if (count !== exp_count)    begin failures++; $display("FAIL bp_count[%0d]: got %0d want %0d", i, count, exp_count); end
      if (im_rd_en !== exp_rd_en) begin failures++; $display("FAIL bp_rd_en[%0d]: got %b want %b", i, im_rd_en, exp_rd_en); end
      if (im_addr !== exp_addr)   begin failures++; $display("FAIL bp_addr[%0d]: got %h want %h", i, im_addr, exp_addr); end
    end
    checks += 3;
    if (count !== CW'(4))     begin failures++; $display("FAIL bp_full_count: got %0d want 4", count); end
    if (im_rd_en !== 1'b0)    begin failures++; $display("FAIL bp_full_rd_en: got %b want 0", im_rd_en); end
    if (im_addr !== 16'h0004) begin failures++; $display("FAIL bp_full_addr: got %h want 0004", im_addr); end
    step(1'b0, 16'h0000, 1'b1);
    step(1'b0, 16'h0000, 1'b0);
    checks += 2;
    if (im_rd_en !== 1'b1)    begin failures++; $display("FAIL bp_resume_rd_en: got %b want 1", im_rd_en); end
    if (im_addr !== 16'h0004) begin failures++; $display("FAIL bp_resume_addr: got %h want 0004", im_addr); end
    step(1'b0, 16'h0000, 1'b0);
    step(1'b0, 16'h0000, 1'b0);
    checks += 2;
    if (count !== CW'(4))  begin failures++; $display("FAIL bp_refill_count: got %0d want 4", count); end
    if (im_rd_en !== 1'b0) begin failures++; $display("FAIL bp_refill_rd_en: got %b want 0", im_rd_en); end
  endtask

  task automatic test_redirect_inflight();
    int guard = 0;
    int first = -1;
    step(1'b1, 16'h0000, 1'b0);
    while (!(mq.size() == 3 && m_infl) && guard < 12) begin
      step(1'b0, 16'h0000, 1'b0);
      guard++;
    end
    checks++;
    if (guard >= 12) begin failures++; $display("FAIL redir_setup: count=3 with inflight never reached, count=%0d", count); end
    step(1'b1, 16'h0040, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 16'h0000, 1'b1);
      if (k == 1) begin
        checks += 3;
        if (count !== '0)         begin failures++; $display("FAIL redir_count: got %0d want 0", count); end
        if (im_rd_en !== 1'b1)    begin failures++; $display("FAIL redir_rd_en: got %b want 1", im_rd_en); end
        if (im_addr !== 16'h0040) begin failures++; $display("FAIL redir_addr: got %h want 0040", im_addr); end
      end
      if (instr_valid === 1'b1 && first < 0) begin
        first = k;
        checks += 2;
        if (instr_pc !== 16'h0040) begin failures++; $display("FAIL redir_first_pc: got %h want 0040", instr_pc); end
        if (instr !== 16'h1040)    begin failures++; $display("FAIL redir_first_instr: got %h want 1040", instr); end
      end
    end
    checks++;
    if (first != LAT + 1) begin failures++; $display("FAIL redir_latency: got %0d want %0d", first, LAT + 1); end
  endtask

  task automatic test_halt();
    logic [15:0] got_pc[$];
    logic [15:0] got_in[$];
    logic [15:0] want;
    halt_addr = 16'h0005;
    step(1'b1, 16'h0000, 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 16'h0000, ($urandom % 4) != 0);
      checks += 5;
      if (instr_valid !== exp_valid) begin failures++; $display("FAIL halt_valid[%0d]: got %b want %b", i, instr_valid, exp_valid); end
      if (instr !== exp_instr)       begin failures++; $display("FAIL halt_instr[%0d]: got %h want %h", i, instr, exp_instr); end
      if (instr_pc !== exp_pc)       begin failures++; $display("FAIL halt_pc[%0d]: got %h want %h", i, instr_pc, exp_pc); end
      if (halted !== exp_halted)     begin failures++; $display("FAIL halt_flag[%0d]: got %b want %b", i, halted, exp_halted); end
      if (im_rd_en === 1'b1 && im_addr > 16'h0005) begin
        failures++; $display("FAIL halt_overfetch[%0d]: issued addr %h, limit 0005", i, im_addr);
      end
      if (instr_valid === 1'b1 && deq === 1'b1) begin
        got_pc.push_back(instr_pc);
        got_in.push_back(instr);
      end
    end
    checks += 2;
    if (halted !== 1'b1)     begin failures++; $display("FAIL halt_final: got %b want 1", halted); end
    if (got_pc.size() != 6)  begin failures++; $display("FAIL halt_drain_size: got %0d want 6", got_pc.size()); end
    for (int k = 0; k < got_pc.size() && k < 6; k++) begin
      want = (k == 5) ? 16'hF000 : 16'h1000 + 16'(k);
      checks += 2;
      if (got_pc[k] !== 16'(k)) begin failures++; $display("FAIL halt_drain_pc[%0d]: got %h want %h", k, got_pc[k], 16'(k)); end
      if (got_in[k] !== want)   begin failures++; $display("FAIL halt_drain_instr[%0d]: got %h want %h", k, got_in[k], want); end
    end
    halt_addr = 16'hBEEF;
    step(1'b1, 16'h0000, 1'b0);
    step(1'b0, 16'h0000, 1'b0);
    checks += 3;
    if (halted !== 1'b0)      begin failures++; $display("FAIL halt_clear: got %b want 0", halted); end
    if (im_rd_en !== 1'b1)    begin failures++; $display("FAIL halt_resume_rd_en: got %b want 1", im_rd_en); end
    if (im_addr !== 16'h0000) begin failures++; $display("FAIL halt_resume_addr: got %h want 0000", im_addr); end
  endtask

  task automatic test_simultaneous();
    int guard = 0;
    step(1'b1, 16'h0000, 1'b0);
    step(1'b0, 16'h0000, 1'b1);
    step(1'b0, 16'h0000, 1'b0);
    checks++;
    if (count !== '0) begin failures++; $display("FAIL sim_deq_empty: got %0d want 0", count); end
    while (!(mq.size() == 2 && m_infl) && guard < 12) begin
      step(1'b0, 16'h0000, 1'b0);
      guard++;
    end
    step(1'b0, 16'h0000, 1'b1);
    checks++;
    if (count !== CW'(2)) begin failures++; $display("FAIL sim_pre_count: got %0d want 2", count); end
    step(1'b0, 16'h0000, 1'b0);
    checks++;
    if (count !== CW'(2)) begin failures++; $display("FAIL sim_enq_deq_count: got %0d want 2", count); end
    step(1'b1, 16'h0100, 1'b1);
    step(1'b0, 16'h0000, 1'b0);
    checks += 2;
    if (count !== '0)        begin failures++; $display("FAIL sim_redir_deq_count: got %0d want 0", count); end
    if (instr_valid !== 1'b0) begin failures++; $display("FAIL sim_redir_deq_valid: got %b want 0", instr_valid); end
  endtask

  task automatic test_random();
    bit r;
    logic [15:0] rpc;
    for (int i = 0; i < 400; i++) begin
      r = ($urandom % 20) == 0;
      case ($urandom % 4)
        0:       rpc = 16'hFFFD;
        1:       rpc = 16'(16'hEFFC + ($urandom % 4));
        default: rpc = 16'($urandom);
      endcase
      step(r, rpc, ($urandom % 5) < 3);
      checks += 7;
      if (instr_valid !== exp_valid) begin failures++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, instr_valid, exp_valid); end
      if (instr !== exp_instr)       begin failures++; $display("FAIL rnd_instr[%0d]: got %h want %h", i, instr, exp_instr); end
      if (instr_pc !== exp_pc)       begin failures++; $display("FAIL rnd_pc[%0d]: got %h want %h", i, instr_pc, exp_pc); end
      if (count !== exp_count)       begin failures++; $display("FAIL rnd_count[%0d]: got %0d want %0d", i, count, exp_count); end
      if (im_rd_en !== exp_rd_en)    begin failures++; $display("FAIL rnd_rd_en[%0d]: got %b want %b", i, im_rd_en, exp_rd_en); end
      if (im_addr !== exp_addr)      begin failures++; $display("FAIL rnd_addr[%0d]: got %h want %h", i, im_addr, exp_addr); end
      if (halted !== exp_halted)     begin failures++; $display("FAIL rnd_halted[%0d]: got %b want %b", i, halted, exp_halted); end
    end
  endtask

  task automatic test_async_reset();
    int first = -1;
    step(1'b1, 16'h0000, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 16'h0000, 1'b1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks += 7;
    if (im_rd_en !== 1'b0)     begin failures++; $display("FAIL areset_rd_en: got %b want 0", im_rd_en); end
    if (im_addr !== RESET_PC)  begin failures++; $display("FAIL areset_addr: got %h want %h", im_addr, RESET_PC); end
    if (instr_valid !== 1'b0)  begin failures++; $display("FAIL areset_valid: got %b want 0", instr_valid); end
    if (instr !== 16'h0000)    begin failures++; $display("FAIL areset_instr: got %h want 0000", instr); end
    if (instr_pc !== 16'h0000) begin failures++; $display("FAIL areset_pc: got %h want 0000", instr_pc); end
    if (count !== '0)          begin failures++; $display("FAIL areset_count: got %0d want 0", count); end
    if (halted !== 1'b0)       begin failures++; $display("FAIL areset_halted: got %b want 0", halted); end
    @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 16'h0000, 1'b1);
      checks += 3;
      if (instr_valid !== exp_valid) begin failures++; $display("FAIL areset_stream_valid[%0d]: got %b want %b", i, instr_valid, exp_valid); end
      if (instr_pc !== exp_pc)       begin failures++; $display("FAIL areset_stream_pc[%0d]: got %h want %h", i, instr_pc, exp_pc); end
      if (im_addr !== exp_addr)      begin failures++; $display("FAIL areset_stream_addr[%0d]: got %h want %h", i, im_addr, exp_addr); end
      if (instr_valid === 1'b1 && first < 0) begin
        first = i;
        checks++;
        if (instr_pc !== RESET_PC) begin failures++; $display("FAIL areset_restart_pc: got %h want %h", instr_pc, RESET_PC); end
      end
    end
    checks++;
    if (first != LAT) begin failures++; $display("FAIL areset_restart_latency: got %0d want %0d", first, LAT); end
  endtask

  initial begin
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    deq         = 1'b0;
    im_rdata    = 16'h0000;
    model_reset();
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_halt();
    test_simultaneous();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
